uart_cmd_responder: RTL and testbench

//   Byte-level command responder on the parallel side of the uart block. Parses binary

---
 rtl/uart_cmd_responder.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_responder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// uart_cmd_responder
//
// Purpose:
//   Host-access bridge between a UART byte stream and an on-chip register bus.
//   Parses binary request frames from the RX byte strobe, performs one register
//   write or read, and returns ACK (0x06, plus read data) or NAK (0x15) through
//   the UART TX byte handshake.
//
//   Frames (address and data bytes MSB first):
//     write : 0x57, ADDR_WIDTH/8 address bytes, DATA_WIDTH/8 data bytes
//     read  : 0x52, ADDR_WIDTH/8 address bytes
//   Responses:
//     write ok : 0x06
//     read ok  : 0x06, DATA_WIDTH/8 data bytes
//     error    : 0x15 (unknown command, parity error, timeout)
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   rx_d/rx_dv    received byte and its 1-cycle strobe
//   rx_parity_ok  parity status of rx_d (tie 1 when no parity is used)
//   tx_d/tx_dv    byte to transmit and its 1-cycle strobe
//   tx_dr         transmitter ready
//   reg_addr      register address
//   reg_wdata     register write data
//   reg_we/re     1-cycle write / read strobes
//   reg_rdata     read data, qualified by reg_rvalid
//   busy          high whenever the responder is not idle
//
// Configuration:
//   UART_CMD_TIMEOUT_EN  when defined, a partial frame idle for TIMEOUT_CLKS
//                        cycles, or a read waiting TIMEOUT_CLKS cycles for
//                        reg_rvalid, is aborted with a NAK. When undefined
//                        there is no timeout logic and only rst recovers.
// -----------------------------------------------------------------------------
module uart_cmd_responder #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_d,
    input  logic                  rx_dv,
    input  logic                  rx_parity_ok,
    output logic [7:0]            tx_d,
    output logic                  tx_dv,
    input  logic                  tx_dr,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_rvalid,
    output logic                  busy
);

    localparam int ABYTES = ADDR_WIDTH / 8;
    localparam int DBYTES = DATA_WIDTH / 8;
    // Response buffer holds the status byte followed by the read data.
    localparam int BUF_W  = DATA_WIDTH + 8;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        DATA      = 3'd2,
        WRITE     = 3'd3,
        READ_REQ  = 3'd4,
        READ_WAIT = 3'd5,
        RESP      = 3'd6,
        NAK       = 3'd7
    } state_t;

    state_t                state, nxt_state;
    logic                  is_write, nxt_is_write;
    logic [2:0]            byte_cnt, nxt_byte_cnt;
    logic [ADDR_WIDTH-1:0] addr_sh, nxt_addr_sh;
    logic [DATA_WIDTH-1:0] data_sh, nxt_data_sh;
    logic [BUF_W-1:0]      tx_buf, nxt_tx_buf;
    logic [2:0]            tx_left, nxt_tx_left;
    logic [ADDR_WIDTH-1:0] nxt_reg_addr;
    logic [DATA_WIDTH-1:0] nxt_reg_wdata;
    logic                  nxt_reg_we, nxt_reg_re;
    logic [7:0]            nxt_tx_d;
    logic                  nxt_tx_dv;
    logic                  nxt_busy;
    logic                  nak_req;
    logic                  tx_fire;
    logic [ADDR_WIDTH-1:0] addr_shifted;
    logic [DATA_WIDTH-1:0] data_shifted;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_run;
    logic             tmo_hit;

    // The timer only runs while waiting on the host or on the register bus.
    assign tmo_run = (state == ADDR) || (state == DATA) || (state == READ_WAIT);
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

    // Inter-byte / read-wait timer, restarted by every received byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (!tmo_run || rx_dv) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= tmo_cnt;
        end
    end
`endif

    // A byte can only leave when the UART is ready and the previous cycle was
    // not itself a strobe (tx_dr is not trusted right after a pulse).
    assign tx_fire      = tx_dr && !tx_dv;
    assign addr_shifted = (addr_sh << 4'd8) | ADDR_WIDTH'(rx_d);
    assign data_shifted = (data_sh << 4'd8) | DATA_WIDTH'(rx_d);

    // Next-state and next-output logic for the frame parser and responder.
    always_comb begin
        nxt_state     = state;
        nxt_is_write  = is_write;
        nxt_byte_cnt  = byte_cnt;
        nxt_addr_sh   = addr_sh;
        nxt_data_sh   = data_sh;
        nxt_tx_buf    = tx_buf;
        nxt_tx_left   = tx_left;
        nxt_reg_addr  = reg_addr;
        nxt_reg_wdata = reg_wdata;
        nxt_reg_we    = 1'b0;
        nxt_reg_re    = 1'b0;
        nxt_tx_d      = tx_d;
        nxt_tx_dv     = 1'b0;
        nak_req       = 1'b0;

        case (state)
            IDLE: begin
                if (rx_dv) begin
                    if (!rx_parity_ok) begin
                        nak_req = 1'b1;
                    end else if (rx_d == CMD_WR) begin
                        nxt_state    = ADDR;
                        nxt_is_write = 1'b1;
                        nxt_byte_cnt = 3'd0;
                    end else if (rx_d == CMD_RD) begin
                        nxt_state    = ADDR;
                        nxt_is_write = 1'b0;
                        nxt_byte_cnt = 3'd0;
                    end else begin
                        nak_req = 1'b1;
                    end
                end else begin
                    nxt_state = IDLE;
                end
            end

            ADDR: begin
                if (rx_dv) begin
                    if (!rx_parity_ok) begin
                        nak_req = 1'b1;
                    end else if (byte_cnt == 3'(ABYTES - 1)) begin
                        // Only the complete address ever reaches reg_addr.
                        nxt_addr_sh  = addr_shifted;
                        nxt_reg_addr = addr_shifted;
                        nxt_byte_cnt = 3'd0;
                        if (is_write) begin
                            nxt_state = DATA;
                        end else begin
                            nxt_state  = READ_REQ;
                            nxt_reg_re = 1'b1;
                        end
                    end else begin
                        nxt_addr_sh  = addr_shifted;
                        nxt_byte_cnt = byte_cnt + 3'd1;
                    end
                end else begin
`ifdef UART_CMD_TIMEOUT_EN
                    if (tmo_hit) begin
                        nak_req = 1'b1;
                    end else begin
                        nak_req = 1'b0;
                    end
`endif
                end
            end

            DATA: begin
                if (rx_dv) begin
                    if (!rx_parity_ok) begin
                        nak_req = 1'b1;
                    end else if (byte_cnt == 3'(DBYTES - 1)) begin
                        nxt_data_sh   = data_shifted;
                        nxt_reg_wdata = data_shifted;
                        nxt_reg_we    = 1'b1;
                        nxt_byte_cnt  = 3'd0;
                        nxt_state     = WRITE;
                    end else begin
                        nxt_data_sh  = data_shifted;
                        nxt_byte_cnt = byte_cnt + 3'd1;
                    end
                end else begin
`ifdef UART_CMD_TIMEOUT_EN
                    if (tmo_hit) begin
                        nak_req = 1'b1;
                    end else begin
                        nak_req = 1'b0;
                    end
`endif
                end
            end

            WRITE: begin
                // reg_we is high during this state; queue the single ACK.
                nxt_state   = RESP;
                nxt_tx_buf  = {ACK_BYTE, {DATA_WIDTH{1'b0}}};
                nxt_tx_left = 3'd1;
            end

            READ_REQ: begin
                nxt_state = READ_WAIT;
            end

            READ_WAIT: begin
                if (reg_rvalid) begin
                    // Capture a private copy so reg_rdata may change afterwards.
                    nxt_state   = RESP;
                    nxt_tx_buf  = {ACK_BYTE, reg_rdata};
                    nxt_tx_left = 3'(DBYTES + 1);
                end else begin
`ifdef UART_CMD_TIMEOUT_EN
                    if (tmo_hit) begin
                        nak_req = 1'b1;
                    end else begin
                        nak_req = 1'b0;
                    end
`endif
                end
            end

            RESP, NAK: begin
                if (tx_fire) begin
                    nxt_tx_dv   = 1'b1;
                    nxt_tx_d    = tx_buf[BUF_W-1 -: 8];
                    nxt_tx_buf  = tx_buf << 4'd8;
                    nxt_tx_left = tx_left - 3'd1;
                    if (tx_left == 3'd1) begin
                        nxt_state = IDLE;
                    end else begin
                        nxt_state = state;
                    end
                end else begin
                    nxt_state = state;
                end
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase

        // Any error discards the frame and sends exactly one NAK byte.
        if (nak_req) begin
            nxt_state    = NAK;
            nxt_tx_buf   = {NAK_BYTE, {DATA_WIDTH{1'b0}}};
            nxt_tx_left  = 3'd1;
            nxt_byte_cnt = 3'd0;
        end else begin
            nxt_tx_left = nxt_tx_left;
        end

        nxt_busy = (nxt_state != IDLE);
    end

    // State and registered outputs; reset abandons any frame or response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= 3'd0;
            addr_sh   <= '0;
            data_sh   <= '0;
            tx_buf    <= '0;
            tx_left   <= 3'd0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            tx_d      <= 8'h00;
            tx_dv     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt_state;
            is_write  <= nxt_is_write;
            byte_cnt  <= nxt_byte_cnt;
            addr_sh   <= nxt_addr_sh;
            data_sh   <= nxt_data_sh;
            tx_buf    <= nxt_tx_buf;
            tx_left   <= nxt_tx_left;
            reg_addr  <= nxt_reg_addr;
            reg_wdata <= nxt_reg_wdata;
            reg_we    <= nxt_reg_we;
            reg_re    <= nxt_reg_re;
            tx_d      <= nxt_tx_d;
            tx_dv     <= nxt_tx_dv;
            busy      <= nxt_busy;
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for uart_cmd_responder (ADDR_WIDTH=8, DATA_WIDTH=16).
// Stimulus tasks push the expected TX bytes, register writes and register
// reads into queues; a monitor pops and compares whenever the DUT strobes.
// The reference model is a plain array of register contents.
// -----------------------------------------------------------------------------
module tb_uart_cmd_responder;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_d;
    logic        rx_dv;
    logic        rx_parity_ok;
    logic [7:0]  tx_d;
    logic        tx_dv;
    logic        tx_dr;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic        reg_rvalid;
    logic        busy;

    uart_cmd_responder #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (16),
        .TIMEOUT_CLKS(100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_d        (rx_d),
        .rx_dv       (rx_dv),
        .rx_parity_ok(rx_parity_ok),
        .tx_d        (tx_d),
        .tx_dv       (tx_dv),
        .tx_dr       (tx_dr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .busy        (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rd[$];
    logic [23:0] exp_wr[$];
    logic [15:0] model_mem [256];
    logic [15:0] ram [256];

    int forced_lat = 0;
    bit hold_tx    = 1'b0;

    logic       prev_dv;
    logic       prev_dr;
    logic [7:0] last_d;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: compares DUT strobes against the scoreboard queues.
    initial begin
        prev_dv = 1'b0;
        prev_dr = 1'b0;
        last_d  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_dv = 1'b0;
                prev_dr = 1'b0;
                last_d  = 8'h00;
            end else begin
                if (tx_dv) begin
                    check("tx_dv_after_idle_cycle", {31'd0, prev_dv}, 32'd0);
                    check("tx_dr_before_pulse", {31'd0, prev_dr}, 32'd1);
                    if (exp_tx.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL tx_unexpected: actual %0h, required no byte", tx_d);
                    end else begin
                        check("tx_byte", {24'd0, tx_d}, {24'd0, exp_tx.pop_front()});
                    end
                    last_d = tx_d;
                end else begin
                    check("tx_d_hold", {24'd0, tx_d}, {24'd0, last_d});
                end
                if (reg_we) begin
                    if (exp_wr.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL we_unexpected: actual %0h/%0h, required no write", reg_addr, reg_wdata);
                    end else begin
                        check("reg_write", {8'd0, reg_addr, reg_wdata}, {8'd0, exp_wr.pop_front()});
                    end
                end
                if (reg_re) begin
                    if (exp_rd.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL re_unexpected: actual %0h, required no read", reg_addr);
                    end else begin
                        check("reg_read_addr", {24'd0, reg_addr}, {24'd0, exp_rd.pop_front()});
                    end
                end
                prev_dv = tx_dv;
                prev_dr = tx_dr;
            end
        end
    end

    // UART transmitter model: drops ready for a few cycles after each byte.
    initial begin
        int cool;
        cool  = 0;
        tx_dr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_tx || rst) begin
                tx_dr = 1'b0;
            end else if (tx_dv) begin
                cool  = $urandom_range(1, 6);
                tx_dr = 1'b0;
            end else if (cool > 0) begin
                cool--;
                tx_dr = 1'b0;
            end else begin
                tx_dr = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Register slave: RAM with variable read latency, junk rdata otherwise.
    initial begin
        int         rd_wait;
        logic [7:0] rd_addr;
        rd_wait    = -1;
        rd_addr    = 8'h00;
        reg_rvalid = 1'b0;
        reg_rdata  = 16'h0000;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            reg_rvalid = 1'b0;
            reg_rdata  = 16'($urandom);
            if (rst) begin
                rd_wait = -1;
            end else begin
                if (reg_we) ram[reg_addr] = reg_wdata;
                if (rd_wait > 0) begin
                    rd_wait--;
                    if (rd_wait == 0) begin
                        reg_rvalid = 1'b1;
                        reg_rdata  = ram[rd_addr];
                        rd_wait    = -1;
                    end
                end
                if (reg_re) begin
                    rd_addr = reg_addr;
                    rd_wait = (forced_lat != 0) ? forced_lat : $urandom_range(1, 4);
                end else if (rd_wait < 0 && !busy && $urandom_range(0, 7) == 0) begin
                    reg_rvalid = 1'b1;   // stray strobe, must be ignored
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ok, input int gap);
        rx_d         = b;
        rx_dv        = 1'b1;
        rx_parity_ok = ok;
        tick();
        rx_dv        = 1'b0;
        rx_parity_ok = 1'b1;
        rx_d         = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0) && n < 600) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 600) begin
            miscompares++;
            $display("FAIL idle_timeout: actual busy=%0b pending_tx=%0d, required idle", busy, exp_tx.size());
        end
        tick();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit junk);
        exp_wr.push_back({a, d});
        exp_tx.push_back(8'h06);
        model_mem[a] = d;
        send_byte(8'h57, 1'b1, $urandom_range(0, 3));
        send_byte(a, 1'b1, $urandom_range(0, 3));
        send_byte(d[15:8], 1'b1, $urandom_range(0, 3));
        send_byte(d[7:0], 1'b1, 0);
        if (junk) send_byte(8'($urandom), 1'b1, 0);
        wait_idle();
    endtask

    task automatic do_read(input logic [7:0] a, input bit junk);
        logic [15:0] d;
        d = model_mem[a];
        exp_rd.push_back(a);
        exp_tx.push_back(8'h06);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
        send_byte(8'h52, 1'b1, $urandom_range(0, 3));
        send_byte(a, 1'b1, 0);
        if (junk) send_byte(8'($urandom), 1'b1, 0);
        wait_idle();
    endtask

    task automatic do_badcmd(input logic [7:0] c, input bit junk);
        logic [7:0] cc;
        cc = c;
        if (cc == 8'h57 || cc == 8'h52) cc = cc ^ 8'h01;
        exp_tx.push_back(8'h15);
        send_byte(cc, 1'b1, 0);
        if (junk) send_byte(8'($urandom), 1'b1, 0);
        wait_idle();
    endtask

    // Parity error on byte 'pos'; the following byte arrives while NAK is pending.
    task automatic do_parity_err(input bit wr, input int pos, input logic [7:0] a, input logic [15:0] d);
        logic [7:0] fb [4];
        int         len;
        fb[0] = wr ? 8'h57 : 8'h52;
        fb[1] = a;
        fb[2] = d[15:8];
        fb[3] = d[7:0];
        len   = wr ? 4 : 2;
        exp_tx.push_back(8'h15);
        for (int i = 0; i <= pos; i++) begin
            send_byte(fb[i], (i != pos), (i == pos) ? 0 : $urandom_range(0, 3));
        end
        if (pos < len - 1) send_byte(fb[pos + 1], 1'b1, 0);
        wait_idle();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_tx_dv"}, {31'd0, tx_dv}, 32'd0);
        check({tag, "_tx_d"}, {24'd0, tx_d}, 32'd0);
        check({tag, "_reg_we"}, {31'd0, reg_we}, 32'd0);
        check({tag, "_reg_re"}, {31'd0, reg_re}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_reg_addr"}, {24'd0, reg_addr}, 32'd0);
        check({tag, "_reg_wdata"}, {16'd0, reg_wdata}, 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #900000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int n;
        int kind;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
        rst          = 1'b1;
        rx_d         = 8'h00;
        rx_dv        = 1'b0;
        rx_parity_ok = 1'b1;
        repeat (3) tick();
        reset_checks("reset");
        rst = 1'b0;
        tick();

        // Write frame.
        do_write(8'h12, 16'hABCD, 1'b0);

        // Read with a 3-cycle bus latency.
        do_write(8'h34, 16'hBEEF, 1'b0);
        forced_lat = 3;
        do_read(8'h34, 1'b0);
        forced_lat = 0;

        // Unknown command, then a normal frame.
        do_badcmd(8'h41, 1'b0);
        do_write(8'h01, 16'h0002, 1'b0);

        // Parity error on the first data byte; CD is dropped.
        do_parity_err(1'b1, 2, 8'h12, 16'hABCD);

        // Reset right after the ACK byte of a read response.
        exp_rd.push_back(8'h34);
        exp_tx.push_back(8'h06);
        exp_tx.push_back(8'hBE);
        exp_tx.push_back(8'hEF);
        send_byte(8'h52, 1'b1, 0);
        send_byte(8'h34, 1'b1, 0);
        n = 0;
        while (!tx_dv && n < 300) begin
            tick();
            n++;
        end
        check("ack_before_reset_seen", {31'd0, tx_dv}, 32'd1);
        hold_tx = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick();
        tick();
        reset_checks("midresp");
        exp_tx.delete();
        rst     = 1'b0;
        hold_tx = 1'b0;
        tick();
        do_read(8'h34, 1'b0);

        // Randomized frame mix.
        for (int f = 0; f < 80; f++) begin
            kind = $urandom_range(0, 9);
            a    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            case (kind)
                0, 1, 2, 3: do_write(a, 16'($urandom), ($urandom_range(0, 2) == 0));
                4, 5, 6:    do_read(a, ($urandom_range(0, 2) == 0));
                7:          do_badcmd(8'($urandom), ($urandom_range(0, 1) == 0));
                default: begin
                    if ($urandom_range(0, 1) == 0) do_parity_err(1'b1, $urandom_range(0, 3), a, 16'($urandom));
                    else                           do_parity_err(1'b0, $urandom_range(0, 1), a, 16'($urandom));
                end
            endcase
        end

        // Partial frame followed by a long idle gap.
`ifdef UART_CMD_TIMEOUT_EN
        exp_tx.push_back(8'h15);
`endif
        send_byte(8'h57, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        repeat (150) tick();
`ifdef UART_CMD_TIMEOUT_EN
        wait_idle();
        check("timeout_busy_cleared", {31'd0, busy}, 32'd0);
`else
        check("no_timeout_busy_held", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        tick();
        reset_checks("recover");
        rst = 1'b0;
        tick();
`endif
        do_write(8'h55, 16'h1234, 1'b0);
        do_read(8'h55, 1'b0);

        repeat (5) tick();
        check("tx_queue_drained", exp_tx.size(), 32'd0);
        check("wr_queue_drained", exp_wr.size(), 32'd0);
        check("rd_queue_drained", exp_rd.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
